// File: rtl/int_arbiter.sv
// Interrupt gateway and priority arbiter with a claim/complete handshake to the handler.
// Define INT_EDGE_EN for edge-triggered gateways; the default build uses level-triggered gateways.
module int_arbiter #(
    parameter int NUM_SRC = 16,
    parameter int PRIO_W  = 3,
    parameter int ID_W    = 5
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_SRC-1:0]        irq_src,
    input  logic [NUM_SRC-1:0]        int_enable,
    input  logic [NUM_SRC*PRIO_W-1:0] int_prio,
    input  logic [PRIO_W-1:0]         threshold,
    input  logic                      claim_req,
    output logic                      claim_valid,
    output logic [ID_W-1:0]           claim_id,
    input  logic                      complete_valid,
    input  logic [ID_W-1:0]           complete_id,
    output logic                      irq_out,
    output logic [ID_W-1:0]           max_id,
    output logic [PRIO_W-1:0]         max_prio
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        INFLIGHT = 2'd2
    } gw_state_t;

    gw_state_t          gw_state [NUM_SRC];
    gw_state_t          gw_next  [NUM_SRC];
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] reenter;
    logic [NUM_SRC-1:0] claim_hit;
    logic [NUM_SRC-1:0] done_hit;
    logic [ID_W-1:0]    best_id;
    logic [PRIO_W-1:0]  best_prio;
    logic               claim_ok;

`ifdef INT_EDGE_EN
    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] edge_flag;
    logic [NUM_SRC-1:0] edge_flag_next;

    assign req     = irq_src & ~irq_prev;
    assign reenter = edge_flag | req;

    // One-deep memory of an edge that arrived while the source was being serviced.
    always_comb begin
        edge_flag_next = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            edge_flag_next[i] = (gw_state[i] == INFLIGHT) && !done_hit[i] && (edge_flag[i] || req[i]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_prev  <= '0;
            edge_flag <= '0;
        end else begin
            irq_prev  <= irq_src;
            edge_flag <= edge_flag_next;
        end
    end
`else
    assign req     = irq_src;
    assign reenter = '0;
`endif

    // A claim only succeeds if the registered winner is still pending.
    always_comb begin
        claim_hit = '0;
        done_hit  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_hit[i] = claim_req && irq_out && (max_id == ID_W'(i + 1)) && (gw_state[i] == PENDING);
            done_hit[i]  = complete_valid && (complete_id == ID_W'(i + 1)) && (gw_state[i] == INFLIGHT);
        end
    end

    assign claim_ok = |claim_hit;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            gw_next[i] = gw_state[i];
            case (gw_state[i])
                IDLE:     if (req[i])       gw_next[i] = PENDING;
                PENDING:  if (claim_hit[i]) gw_next[i] = INFLIGHT;
                INFLIGHT: if (done_hit[i])  gw_next[i] = reenter[i] ? PENDING : IDLE;
                default:                    gw_next[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_SRC; i++) gw_state[i] <= IDLE;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) gw_state[i] <= gw_next[i];
        end
    end

    // Strict greater-than while scanning upward keeps ties on the lowest ID.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if ((gw_state[i] == PENDING) && int_enable[i] &&
                (int_prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
                best_prio = int_prio[i*PRIO_W +: PRIO_W];
                best_id   = ID_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            max_id      <= '0;
            max_prio    <= '0;
            irq_out     <= 1'b0;
            claim_valid <= 1'b0;
            claim_id    <= '0;
        end else begin
            max_id      <= best_id;
            max_prio    <= best_prio;
            irq_out     <= (best_prio > threshold);
            claim_valid <= claim_req;
            if (claim_req) claim_id <= claim_ok ? max_id : '0;
        end
    end

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter: vector table for arbitration, scoreboard for claim responses.
// Sections specific to INT_EDGE_EN follow the same macro as the design.
module tb_int_arbiter;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [15:0] irq_src = '0;
    logic [15:0] int_enable = '0;
    logic [47:0] int_prio = '0;
    logic [2:0]  threshold = '0;
    logic        claim_req = 1'b0;
    logic        claim_valid;
    logic [4:0]  claim_id;
    logic        complete_valid = 1'b0;
    logic [4:0]  complete_id = '0;
    logic        irq_out;
    logic [4:0]  max_id;
    logic [2:0]  max_prio;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    typedef struct {
        int due;
        int id;
    } sb_t;
    sb_t sb[$];
    sb_t mon_e;

    typedef struct {
        logic [15:0] en;
        logic [2:0]  p2;
        logic [2:0]  p7;
        logic [2:0]  p12;
        logic [2:0]  th;
        logic [4:0]  exp_id;
        logic [2:0]  exp_prio;
        logic        exp_irq;
    } vec_t;
    vec_t vecs[11];

    int_arbiter dut (
        .clk(clk),
        .rstn(rstn),
        .irq_src(irq_src),
        .int_enable(int_enable),
        .int_prio(int_prio),
        .threshold(threshold),
        .claim_req(claim_req),
        .claim_valid(claim_valid),
        .claim_id(claim_id),
        .complete_valid(complete_valid),
        .complete_id(complete_id),
        .irq_out(irq_out),
        .max_id(max_id),
        .max_prio(max_prio)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_prio(input int src, input logic [2:0] p);
        int_prio[(src-1)*3 +: 3] = p;
    endtask

    task automatic claim(input int exp_id);
        claim_req = 1'b1;
        sb.push_back('{cyc + 1, exp_id});
    endtask

    task automatic apply_stimulus(input vec_t v);
        int_enable = v.en;
        int_prio   = '0;
        set_prio(1, 3'd7);
        set_prio(2, v.p2);
        set_prio(7, v.p7);
        set_prio(12, v.p12);
        threshold  = v.th;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        irq_src = '0;
        claim_req = 1'b0;
        complete_valid = 1'b0;
        complete_id = '0;
        #1;
        check_output("reset_async_max_id", max_id, 0);
        check_output("reset_async_irq", irq_out, 0);
        tick(2);
        rstn = 1'b1;
        tick(1);
    endtask

    // Every claim response must appear exactly one cycle after its request.
    always @(negedge clk) begin
        if (claim_valid) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL claim_spurious: got claim_valid=1 id=%0d, expected no response", claim_id);
            end else begin
                mon_e = sb.pop_front();
                check_output("claim_cycle", cyc, mon_e.due);
                check_output("claim_id", claim_id, mon_e.id);
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            compared++;
            mismatched++;
            $display("[TB] FAIL claim_missing: got claim_valid=0, expected response id=%0d at cycle %0d", mon_e.id, mon_e.due);
        end
    end

    initial begin
        int exp_irq_after;
        int exp_id_after;

        vecs[0]  = '{16'hFFFF, 3'd3, 3'd0, 3'd0, 3'd3, 5'd2,  3'd3, 1'b0};
        vecs[1]  = '{16'hFFFF, 3'd3, 3'd0, 3'd0, 3'd2, 5'd2,  3'd3, 1'b1};
        vecs[2]  = '{16'hFFFD, 3'd3, 3'd0, 3'd0, 3'd2, 5'd0,  3'd0, 1'b0};
        vecs[3]  = '{16'hFFFF, 3'd3, 3'd0, 3'd0, 3'd2, 5'd2,  3'd3, 1'b1};
        vecs[4]  = '{16'hFFFF, 3'd3, 3'd5, 3'd5, 3'd2, 5'd7,  3'd5, 1'b1};
        vecs[5]  = '{16'hFFBF, 3'd3, 3'd5, 3'd5, 3'd2, 5'd12, 3'd5, 1'b1};
        vecs[6]  = '{16'hFFFF, 3'd3, 3'd2, 3'd6, 3'd6, 5'd12, 3'd6, 1'b0};
        vecs[7]  = '{16'hFFFF, 3'd7, 3'd7, 3'd7, 3'd0, 5'd2,  3'd7, 1'b1};
        vecs[8]  = '{16'h0000, 3'd7, 3'd7, 3'd7, 3'd0, 5'd0,  3'd0, 1'b0};
        vecs[9]  = '{16'hFFFF, 3'd0, 3'd0, 3'd0, 3'd0, 5'd0,  3'd0, 1'b0};
        vecs[10] = '{16'hFFFF, 3'd1, 3'd0, 3'd0, 3'd0, 5'd2,  3'd1, 1'b1};

        #2;
        do_reset();
        tick(1);
        check_output("idle_irq", irq_out, 0);
        check_output("idle_max_id", max_id, 0);
        check_output("idle_max_prio", max_prio, 0);
        claim(0);
        tick(1);
        claim_req = 1'b0;
        tick(1);

        // Priority and tie-break: 3 and 5 share prio 4, 9 is lower.
        int_enable = 16'hFFFF;
        int_prio = '0;
        set_prio(3, 3'd4);
        set_prio(5, 3'd4);
        set_prio(9, 3'd2);
        threshold = 3'd1;
        irq_src = 16'h0114;
        tick(1);
        irq_src = '0;
        tick(1);
        check_output("tie_max_id", max_id, 3);
        check_output("tie_max_prio", max_prio, 4);
        check_output("tie_irq", irq_out, 1);
        claim(3);
        tick(1);
        claim_req = 1'b0;
        check_output("stale_max_id", max_id, 3);
        tick(1);
        check_output("next_max_id", max_id, 5);
        check_output("next_max_prio", max_prio, 4);

        // Reset with pending and in-flight sources outstanding.
        do_reset();
        tick(1);
        check_output("midreset_max_id", max_id, 0);
        check_output("midreset_irq", irq_out, 0);

        // Threshold/enable table over pending sources 2, 7, 12; source 1 has prio 7 but never requests.
        apply_stimulus(vecs[0]);
        irq_src = 16'h0842;
        tick(1);
        irq_src = '0;
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i]);
            tick(1);
            check_output($sformatf("vec%0d_max_id", i), max_id, vecs[i].exp_id);
            check_output($sformatf("vec%0d_max_prio", i), max_prio, vecs[i].exp_prio);
            check_output($sformatf("vec%0d_irq", i), irq_out, vecs[i].exp_irq);
        end

        // Back-to-back claims: second one sees a stale winner.
        do_reset();
        int_enable = 16'hFFFF;
        int_prio = '0;
        set_prio(1, 3'd5);
        set_prio(4, 3'd3);
        threshold = 3'd0;
        irq_src = 16'h0009;
        tick(1);
        irq_src = '0;
        tick(1);
        check_output("b2b_max_id", max_id, 1);
        claim(1);
        tick(1);
        claim(0);
        tick(1);
        claim_req = 1'b0;
        check_output("b2b_next_max_id", max_id, 4);
        tick(1);
        claim(4);
        tick(1);
        claim_req = 1'b0;
        tick(1);
        check_output("b2b_drained_max_id", max_id, 0);
        check_output("b2b_drained_irq", irq_out, 0);

        // Complete handling with source 7 still asserted.
        do_reset();
        int_enable = 16'hFFFF;
        int_prio = '0;
        set_prio(7, 3'd4);
        threshold = 3'd0;
        irq_src = 16'h0040;
        tick(2);
        check_output("cmp_max_id", max_id, 7);
        claim(7);
        tick(1);
        claim_req = 1'b0;
        tick(1);
        check_output("cmp_inflight_max_id", max_id, 0);
        complete_valid = 1'b1;
        complete_id = 5'd0;
        tick(1);
        complete_id = 5'd20;
        tick(1);
        complete_id = 5'd23;
        tick(1);
        complete_valid = 1'b0;
        tick(3);
        check_output("cmp_ignored_irq", irq_out, 0);
        check_output("cmp_ignored_max_id", max_id, 0);
        complete_valid = 1'b1;
        complete_id = 5'd7;
        tick(1);
        complete_valid = 1'b0;
        check_output("cmp_n1_irq", irq_out, 0);
        tick(1);
        check_output("cmp_n2_irq", irq_out, 0);
        tick(1);
`ifdef INT_EDGE_EN
        exp_irq_after = 0;
        exp_id_after = 0;
`else
        exp_irq_after = 1;
        exp_id_after = 7;
`endif
        check_output("cmp_n3_irq", irq_out, exp_irq_after);
        check_output("cmp_n3_max_id", max_id, exp_id_after);

`ifdef INT_EDGE_EN
        // Two edges while in flight collapse into one re-pend on complete.
        do_reset();
        int_enable = 16'hFFFF;
        int_prio = '0;
        set_prio(6, 3'd2);
        threshold = 3'd0;
        irq_src = 16'h0020;
        tick(1);
        irq_src = '0;
        tick(1);
        check_output("edge_max_id", max_id, 6);
        claim(6);
        tick(1);
        claim_req = 1'b0;
        tick(1);
        irq_src = 16'h0020;
        tick(1);
        irq_src = '0;
        tick(1);
        irq_src = 16'h0020;
        tick(1);
        irq_src = '0;
        tick(1);
        check_output("edge_inflight_max_id", max_id, 0);
        complete_valid = 1'b1;
        complete_id = 5'd6;
        tick(1);
        complete_valid = 1'b0;
        tick(1);
        check_output("edge_repend_max_id", max_id, 6);
        check_output("edge_repend_irq", irq_out, 1);
        claim(6);
        tick(1);
        claim_req = 1'b0;
        tick(2);
        check_output("edge_claimed_max_id", max_id, 0);
        claim(0);
        tick(1);
        claim_req = 1'b0;
        complete_valid = 1'b1;
        complete_id = 5'd6;
        tick(1);
        complete_valid = 1'b0;
        tick(2);
        check_output("edge_final_max_id", max_id, 0);
        check_output("edge_final_irq", irq_out, 0);
`endif

        tick(3);
        check_output("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
